bin2bcd_seq: RTL

- Sequential, parametrised binary-to-BCD converter using iterative double-dabble (shift-add-3), one input bit per clock.
- Replaces the combinational divide/modulo converter used by the clock display path.
- Generalises input width and digit count, and adds a start/done handshake and overflow detection.
- Sits between the time/counter registers and the seven-segment digit multiplexer.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bin2bcd_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of decimal digits needed to hold 2^bin_w - 1.
  function automatic int min_digits(input int bin_w);
    logic [63:0] max_v;
    int          n;
    max_v = (64'd1 << bin_w) - 64'd1;
    n     = 1;
    while (max_v >= 64'd10) begin
      max_v = max_v / 64'd10;
      n     = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: add 3 to a BCD digit when it is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Digits 5..9 become 8..12, so the sum never wraps the nibble.
  always_comb begin
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock, with start/done handshake.
// Optional macro BIN2BCD_SAT_EN: on overflow the result saturates to all nines.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              binary,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // When the digit count covers the full input range no carry can leave the top digit.
  localparam bit OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));
`ifdef BIN2BCD_SAT_EN
  localparam logic [SCR_W-1:0] ALL_NINES = {DIGITS{4'h9}};
`endif

  if ((BIN_W < 2) || (BIN_W > 32) || (DIGITS < 1) || (DIGITS > 10)) begin : g_bad_param
    $error("bin2bcd_seq: BIN_W must be 2..32 and DIGITS 1..10");
  end

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [SCR_W-1:0]   scr_adj_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .digit_o (scr_adj_s[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  // Next-state and datapath for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          shift_d = binary;
          scr_d   = {SCR_W{1'b0}};
          cnt_d   = CNT_INIT;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        scr_d   = {scr_adj_s[SCR_W-2:0], shift_q[BIN_W-1]};
        ovf_d   = ovf_q | (OVF_POSSIBLE & scr_adj_s[SCR_W-1]);
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ZERO) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        overflow_d = ovf_q;
`ifdef BIN2BCD_SAT_EN
        if (ovf_q) begin
          bcd_d = ALL_NINES;
        end else begin
          bcd_d = scr_q;
        end
`else
        bcd_d = scr_q;
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= {BIN_W{1'b0}};
      scr_q      <= {SCR_W{1'b0}};
      cnt_q      <= CNT_ZERO;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= {SCR_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule
